// File: rtl/junction_pkg.sv
// Shared definitions for the junction controller path: congestion FSM encoding
// and default thresholds, reused by the detector and the controller testbench.
package junction_pkg;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        HOLD      = 2'd1,
        CONGESTED = 2'd2
    } cd_state_e;

    localparam int DEF_CNT_W       = 6;
    localparam int DEF_HIGH_TH     = 20;
    localparam int DEF_LOW_TH      = 12;
    localparam int DEF_HOLD_CYCLES = 8;

endpackage

// File: rtl/congestion_detector_sensor_edge.sv
// Presence-sensor front end: optional 2-flop synchronizer (CONGESTION_DETECTOR_SYNC_EN)
// followed by a rising-edge pulse generator, so a held level counts once.
module sensor_edge (
    input  logic clock,
    input  logic reset,
    input  logic sens_i,
    output logic evt_o
);

    logic sens_s;
    logic prev_q;

`ifdef CONGESTION_DETECTOR_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for sensors asynchronous to clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sens_i};
        end
    end

    assign sens_s = sync_q[1];
`else
    assign sens_s = sens_i;
`endif

    // Previous-cycle sample of the (possibly synchronized) sensor level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sens_s;
        end
    end

    assign evt_o = sens_s & ~prev_q;

endmodule

// File: rtl/congestion_detector.sv
// Tunnel occupancy counter with saturation/error flag and a hysteresis + minimum-hold
// congestion FSM. Optional input synchronizers: CONGESTION_DETECTOR_SYNC_EN.
module congestion_detector
    import junction_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HIGH_TH     = DEF_HIGH_TH,
    parameter int LOW_TH      = DEF_LOW_TH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             car_in,
    input  logic             car_out,
    output logic [CNT_W-1:0] occupancy,
    output logic             congestion,
    output logic             error
);

    localparam int               HC_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] OCC_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] OCC_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] HIGH_C    = CNT_W'(HIGH_TH);
    localparam logic [CNT_W-1:0] LOW_C     = CNT_W'(LOW_TH);
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0]  HC_ZERO   = {HC_W{1'b0}};

    logic             in_evt_s;
    logic             out_evt_s;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic             err_q;
    logic             err_d;
    cd_state_e        state_q;
    logic [HC_W-1:0]  hold_cnt_q;
    logic             congestion_q;

    sensor_edge u_entry_edge (
        .clock (clock),
        .reset (reset),
        .sens_i(car_in),
        .evt_o (in_evt_s)
    );

    sensor_edge u_exit_edge (
        .clock (clock),
        .reset (reset),
        .sens_i(car_out),
        .evt_o (out_evt_s)
    );

    // Next occupancy: single entry/exit events move the count; saturate and flag at the rails
    always_comb begin
        occ_d = occ_q;
        err_d = err_q;
        if (in_evt_s && !out_evt_s) begin
            if (occ_q == OCC_MAX) begin
                err_d = 1'b1;
            end else begin
                occ_d = occ_q + CNT_W'(1);
            end
        end else if (out_evt_s && !in_evt_s) begin
            if (occ_q == OCC_ZERO) begin
                err_d = 1'b1;
            end else begin
                occ_d = occ_q - CNT_W'(1);
            end
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy and sticky error registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q <= OCC_ZERO;
            err_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            err_q <= err_d;
        end
    end

    // Congestion FSM on registered occupancy; congestion_q tracks the next state so it
    // equals the decoded state register without a combinational output path
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FREE;
            hold_cnt_q   <= HC_ZERO;
            congestion_q <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    if (occ_q >= HIGH_C) begin
                        state_q      <= HOLD;
                        hold_cnt_q   <= HOLD_LOAD;
                        congestion_q <= 1'b1;
                    end else begin
                        congestion_q <= 1'b0;
                    end
                end
                HOLD: begin
                    congestion_q <= 1'b1;
                    if (hold_cnt_q == HC_ZERO) begin
                        state_q <= CONGESTED;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HC_W'(1);
                    end
                end
                CONGESTED: begin
                    if (occ_q <= LOW_C) begin
                        state_q      <= FREE;
                        congestion_q <= 1'b0;
                    end else begin
                        congestion_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= FREE;
                    hold_cnt_q   <= HC_ZERO;
                    congestion_q <= 1'b0;
                end
            endcase
        end
    end

    assign occupancy  = occ_q;
    assign congestion = congestion_q;
    assign error      = err_q;

endmodule

// File: tb/tb_congestion_detector.sv
// Scoreboard bench for congestion_detector: per-cycle expectations from a behavioural
// traffic model are queued by the stimulus and compared by an independent monitor.
module tb_congestion_detector;
    import junction_pkg::*;

    localparam int CNT_W   = DEF_CNT_W;
    localparam int HIGH    = DEF_HIGH_TH;
    localparam int LOW     = DEF_LOW_TH;
    localparam int HOLDC   = DEF_HOLD_CYCLES;
    localparam int OCC_MAX = (1 << CNT_W) - 1;
`ifdef CONGESTION_DETECTOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clock;
    logic             reset;
    logic             car_in;
    logic             car_out;
    logic [CNT_W-1:0] occupancy;
    logic             congestion;
    logic             error;

    typedef struct {
        int occ;
        bit cong;
        bit err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // behavioural model state
    int m_occ;
    bit m_cong;
    bit m_err;
    int m_held;
    bit m_pin, m_pout;
    bit m_i1, m_i2, m_o1, m_o2;

    congestion_detector dut (
        .clock     (clock),
        .reset     (reset),
        .car_in    (car_in),
        .car_out   (car_out),
        .occupancy (occupancy),
        .congestion(congestion),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_cong = 0; m_err = 0; m_held = 0;
        m_pin = 0; m_pout = 0;
        m_i1 = 0; m_i2 = 0; m_o1 = 0; m_o2 = 0;
    endtask

    // One clock edge of the traffic rules: events from level rises, congestion from last count
    task automatic model_edge(input bit ci, input bit co);
        bit si, so, ei, eo;
        int old_occ;
`ifdef CONGESTION_DETECTOR_SYNC_EN
        si = m_i2; so = m_o2;
        m_i2 = m_i1; m_i1 = ci;
        m_o2 = m_o1; m_o1 = co;
`else
        si = ci; so = co;
`endif
        ei = si && !m_pin;
        eo = so && !m_pout;
        m_pin = si; m_pout = so;
        old_occ = m_occ;

        if (!m_cong) begin
            if (old_occ >= HIGH) begin
                m_cong = 1;
                m_held = 0;
            end
        end else begin
            m_held++;
            // HOLD_CYCLES cycles of hold, then one CONGESTED evaluation before release
            if (m_held > HOLDC && old_occ <= LOW) m_cong = 0;
        end

        if (ei && !eo) begin
            if (m_occ == OCC_MAX) m_err = 1; else m_occ++;
        end else if (eo && !ei) begin
            if (m_occ == 0) m_err = 1; else m_occ--;
        end
    endtask

    task automatic cyc(input bit ci, input bit co);
        exp_t e;
        @(negedge clock);
        car_in  = ci;
        car_out = co;
        model_edge(ci, co);
        e.occ = m_occ; e.cong = m_cong; e.err = m_err;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    task automatic goto_occ(input int target);
        while (m_occ < target) begin cyc(1'b1, 1'b0); idle(1 + LAT); end
        while (m_occ > target) begin cyc(1'b0, 1'b1); idle(1 + LAT); end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; car_in = 1'b0; car_out = 1'b0;
        #1;
        chk("reset_occ", 32'(occupancy), 32'd0);
        chk("reset_cong", 32'(congestion), 32'd0);
        chk("reset_err", 32'(error), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: compare every presented output cycle against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (occupancy !== CNT_W'(e.occ) || congestion !== e.cong || error !== e.err) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got occ=%0d cong=%0b err=%0b exp occ=%0d cong=%0b err=%0b",
                             $time, occupancy, congestion, error, e.occ, e.cong, e.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; car_in = 1'b0; car_out = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        do_reset();

        // 20 entry pulses spaced 3 cycles apart
        repeat (20) begin cyc(1'b1, 1'b0); idle(2 + LAT); end
        idle(2);
        settle();
        chk("occ_20", 32'(occupancy), 32'd20);
        chk("cong_at_20", 32'(congestion), 32'd1);
        chk("err_clear", 32'(error), 32'd0);

        // held level counts once
        repeat (10) cyc(1'b1, 1'b0);
        idle(3 + LAT);
        settle();
        chk("level_once", 32'(occupancy), 32'd21);

        // hold check: rise to 20 then straight back down to 11
        do_reset();
        goto_occ(20);
        goto_occ(11);
        idle(4);
        settle();
        chk("hold_release", 32'(congestion), 32'd0);

        // hysteresis
        do_reset();
        goto_occ(20);
        idle(12);
        repeat (15) goto_occ($urandom_range(13, 19));
        settle();
        chk("hyst_high", 32'(congestion), 32'd1);
        goto_occ(12);
        idle(1);
        settle();
        chk("hyst_drop", 32'(congestion), 32'd0);
        goto_occ(19);
        idle(3);
        settle();
        chk("hyst_stay_low", 32'(congestion), 32'd0);

        // simultaneous entry and exit
        goto_occ(5);
        cyc(1'b1, 1'b1);
        idle(2 + LAT);
        settle();
        chk("simul_5", 32'(occupancy), 32'd5);

        // underflow
        do_reset();
        cyc(1'b0, 1'b1);
        idle(2 + LAT);
        settle();
        chk("uflow_occ", 32'(occupancy), 32'd0);
        chk("uflow_err", 32'(error), 32'd1);
        goto_occ(16);
        repeat (300) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(2 + LAT);
        settle();
        chk("err_sticky", 32'(error), 32'd1);

        // overflow
        do_reset();
        goto_occ(OCC_MAX);
        cyc(1'b1, 1'b0);
        idle(2 + LAT);
        settle();
        chk("oflow_occ", 32'(occupancy), 32'(OCC_MAX));
        chk("oflow_err", 32'(error), 32'd1);

        // random traffic from a fresh start
        do_reset();
        goto_occ(14);
        repeat (400) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(4);

        // asynchronous reset in the middle of HOLD
        do_reset();
        goto_occ(20);
        idle(2);
        @(posedge clock);
        #3;
        chk("pre_reset_cong", 32'(congestion), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_occ", 32'(occupancy), 32'd0);
        chk("async_cong", 32'(congestion), 32'd0);
        chk("async_err", 32'(error), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        idle(4);

        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
